// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider (a / b), one restoring quotient bit per cycle.
// Denormals flush to zero, mantissa is truncated; valid/ready on both sides, one op in flight.
module fp_div_seq #(
  parameter int          ITER    = 25,
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} stateT;

  stateT       state, nextState;
  logic        sign;
  logic [7:0]  ea, eb;
  logic [23:0] mb;
  logic [24:0] rem, q;
  logic [4:0]  cnt;
  logic        isSpec;
  logic [31:0] specRes;

  // Operand classification on the live inputs; only used on the accepting edge
  logic        aZero, bZero, aInf, bInf, aNan, bNan, special;
  logic [31:0] specVal;
  logic        inSign;

  always_comb begin
    inSign  = a[31] ^ b[31];
    aZero   = (a[30:23] == '0);
    bZero   = (b[30:23] == '0);
    aInf    = (a[30:23] == '1) && (a[22:0] == '0);
    bInf    = (b[30:23] == '1) && (b[22:0] == '0);
    aNan    = (a[30:23] == '1) && (a[22:0] != '0);
    bNan    = (b[30:23] == '1) && (b[22:0] != '0);
    special = 1'b1;
    specVal = '0;
    if (aNan || bNan || (aInf && bInf) || (aZero && bZero)) begin
      specVal = NAN_VAL;
    end else if (aInf || bZero) begin
      specVal = {inSign, 8'hFF, 23'h0};
    end else if (aZero || bInf) begin
      specVal = {inSign, 31'h0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step: rem < 2*mb always holds, so the difference fits in 24 bits
  logic        ge;
  logic [24:0] diff, remNext;

  always_comb begin
    ge      = (rem >= {1'b0, mb});
    diff    = rem - {1'b0, mb};
    remNext = ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
  end

  // Normalisation: q[24] set means the quotient is in [1,2)
  logic [9:0]  eRaw;
  logic [22:0] frac;
  logic [31:0] normRes;

  always_comb begin
    frac = q[24] ? q[23:1] : q[22:0];
    eRaw = {2'b00, ea} - {2'b00, eb} + (q[24] ? 10'd127 : 10'd126);
    if ($signed(eRaw) >= 10'sd255) begin
      normRes = {sign, 8'hFF, 23'h0};
    end else if ($signed(eRaw) <= 10'sd0) begin
      normRes = {sign, 31'h0};
    end else begin
      normRes = {sign, eRaw[7:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = special ? NORM : DIVIDE;
      DIVIDE:  if (cnt == 5'(ITER - 1)) nextState = NORM;
      NORM:    nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign    <= 1'b0;
      ea      <= '0;
      eb      <= '0;
      mb      <= '0;
      rem     <= '0;
      q       <= '0;
      cnt     <= '0;
      isSpec  <= 1'b0;
      specRes <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign    <= inSign;
          ea      <= a[30:23];
          eb      <= b[30:23];
          mb      <= {1'b1, b[22:0]};
          rem     <= {2'b01, a[22:0]};
          q       <= '0;
          cnt     <= '0;
          isSpec  <= special;
          specRes <= specVal;
        end
        DIVIDE: begin
          q   <= {q[23:0], ge};
          rem <= remNext;
          cnt <= cnt + 5'd1;
        end
        NORM:    result <= isSpec ? specRes : normRes;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
